// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), LSB first,
// one bit per clock through a single registered borrow flop.
// The per-bit arithmetic is the same full-adder cell used by the clocked
// ripple-carry adder: the subtrahend bit is inverted and the carry is the
// complement of the borrow, so borrow_out = ~carry_out.
// Control is a start/busy/done handshake around a three-state FSM
// (IDLE -> SHIFT x WIDTH -> DONE -> IDLE). All outputs are registered.

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             busy,
    output logic             done
);

    // Counter only has to reach WIDTH-1; never narrower than one bit.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Full-adder cell shared with the ripple-carry adder: returns {cout, sum}.
    function automatic logic [1:0] full_add(
        input logic x,
        input logic y,
        input logic ci
    );
        logic sum_v;
        logic cout_v;
        sum_v  = x ^ y ^ ci;
        cout_v = (x & y) | (x & ci) | (y & ci);
        return {cout_v, sum_v};
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_b_out;
    logic               r_busy;
    logic               r_done;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic               w_last;
    logic               w_load;
    logic               w_shift;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [1:0]         w_fa;
    logic               w_bit;
    logic               w_borrow_nxt;

    // Subtract step: a + ~b + ~borrow through the adder cell.
    // Sum is the difference bit, the complemented carry is the new borrow.
    always_comb begin
        w_fa         = full_add(r_a_sh[0], ~r_b_sh[0], ~r_borrow);
        w_bit        = w_fa[0];
        w_borrow_nxt = ~w_fa[1];
    end

    // Final bit of the operation is the one processed when the counter
    // holds WIDTH-1.
    always_comb begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
            w_last = 1'b1;
        end else begin
            w_last = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Hold the current control state; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // Start is honoured only in IDLE; SHIFT and DONE ignore it entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    // Decode datapath strobes and the next values of the registered
    // busy/done flags from the current state.
    always_comb begin
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_busy_nxt = 1'b1;
                end else begin
                    w_load     = 1'b0;
                    w_busy_nxt = 1'b0;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end else begin
                    w_busy_nxt = 1'b1;
                    w_done_nxt = 1'b0;
                end
            end
            ST_DONE: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Operand shift registers, borrow flop and bit counter: loaded on an
    // accepted start, advanced once per SHIFT cycle, otherwise frozen so
    // later changes on a/b cannot disturb an operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= {WIDTH{1'b0}};
            r_b_sh   <= {WIDTH{1'b0}};
            r_borrow <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
        end else if (w_load) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
        end else if (w_shift) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_borrow <= w_borrow_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
        end else begin
            r_a_sh   <= r_a_sh;
            r_b_sh   <= r_b_sh;
            r_borrow <= r_borrow;
            r_cnt    <= r_cnt;
        end
    end

    // Result register: difference bits enter at the MSB and move right, so
    // after WIDTH shifts bit 0 sits in diff[0]. The previous result stays
    // visible through IDLE and the load edge until the first shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff <= {WIDTH{1'b0}};
        end else if (w_shift) begin
            r_diff <= {w_bit, r_diff[WIDTH-1:1]};
        end else begin
            r_diff <= r_diff;
        end
    end

    // Final borrow is captured only on the last shift and held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_out <= 1'b0;
        end else if (w_shift && w_last) begin
            r_b_out <= w_borrow_nxt;
        end else begin
            r_b_out <= r_b_out;
        end
    end

    // Registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign diff  = r_diff;
    assign b_out = r_b_out;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor computing diff = a - b, LSB first, one bit per clock through a single registered borrow flop. It is the subtract counterpart of the team's clocked ripple-carry adder and reuses the same full-adder cell arithmetic, with b inverted and the carry replaced by a borrow. A start/busy/done handshake lets a controller launch one operation and collect the result. The block sits beside the adder in the combinational-elements library as the sequential, area-minimal subtract path.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2 to 32)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  launch request; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
diff  output  WIDTH  result a - b modulo 2^WIDTH; valid when done=1 and held until the next accepted start
b_out  output  1  final borrow (1 when a < b unsigned); same validity as diff
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse when diff and b_out become valid

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE
  - diff=0, b_out=0, busy=0, done=0
  - internal shift registers, borrow flop and bit counter cleared
  - Reset mid-operation aborts the operation; no done pulse is produced.
- State machine: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - With start=1 at edge E0: latch a and b into shift registers, clear the borrow flop, set counter=0, go to SHIFT, busy=1.
  - diff and b_out keep their previous values until the first SHIFT edge.
  - With start=0: remain in IDLE.
- SHIFT, at each edge, with x=a_sh[0], y=b_sh[0], c=borrow:
  - result bit = x ^ y ^ c
  - borrow_next = (~x & y) | (~x & c) | (y & c)
  - Shift the result bit into diff from the MSB side (right shift), so after WIDTH shifts diff[0] holds bit 0.
  - Shift a_sh and b_sh right by 1. Increment the counter.
  - At the edge where counter == WIDTH-1 (edge E0+WIDTH): go to DONE, busy=0, done=1, b_out=borrow_next.
- DONE: lasts one cycle, then returns to IDLE with done=0. diff and b_out are held.
- Latency: done is high during the cycle following edge E0+WIDTH, which is WIDTH+1 cycles after start is sampled. busy is high for exactly WIDTH cycles.
- start while busy=1 or in DONE is ignored. It is neither queued nor allowed to corrupt the in-flight operands. Changes on a or b after E0 are ignored.
- Back-to-back operation: start may be asserted in the cycle after done; throughput is one operation per WIDTH+2 cycles.
- Wrap-around: diff is modulo 2^WIDTH; b_out is the only underflow indication.
- Counter width: $clog2(WIDTH), minimum 1 bit.

Test Plan:
- WIDTH=4, a=3, b=2, start pulsed one cycle -> busy high for 4 cycles; done pulses 5 cycles after the start edge; diff=4'b0001, b_out=0.
- a=2, b=3 -> diff=4'b1111, b_out=1. Then a=0, b=15 -> diff=4'b0001, b_out=1. Then a=9, b=9 -> diff=4'b0000, b_out=0, issued back-to-back, each start one cycle after the previous done.
- During a 7-4 operation, pulse start with a=1, b=14 while busy=1, and change a and b every cycle -> result still diff=4'b0011, b_out=0; exactly one done pulse.
- Assert rst_n=0 asynchronously two cycles into an operation -> all outputs 0 immediately, no done pulse; a new 5-5 operation after release gives diff=0, b_out=0.
- WIDTH=8 instance, exhaustive loop over all a and b in 0..255 -> {b_out,diff} equals (a - b) mod 512 with b_out = (a < b); done latency is 9 cycles every time.
